// File: rtl/hazard_controller.sv
// hazard_controller
// Pipeline hazard scheduler for a 5-stage RV32I core. It keeps a shadow copy
// of the EX/MEM/WB destination and write-back information and derives
// forwarding selects, load-use stalls, redirect flushes and the data-memory
// freeze from it. It also keeps saturating stall/flush event counters.
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   id_rs1/id_rs2/id_use_rs1/2     source operands of the ID instruction
//   id_rd/id_regwrite/id_wb_sel    destination info of the ID instruction
//   ex_redirect                    taken branch / jump resolved in EX
//   dmem_busy                      data memory stall, freezes the pipe
//   stall_f/stall_d                hold PC / IF-ID
//   flush_d/flush_e                clear IF-ID / ID-EX
//   stall_all                      freeze ID-EX, EX-MEM, MEM-WB
//   fwd_a/fwd_b                    EX operand sources (00 rf, 01 MEM, 10 WB)
//   stall_cnt/flush_cnt            saturating event counters
module hazard_controller #(
    parameter int CNT_W   = 32,
    parameter int XLEN_RA = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [XLEN_RA-1:0] id_rs1,
    input  logic [XLEN_RA-1:0] id_rs2,
    input  logic               id_use_rs1,
    input  logic               id_use_rs2,
    input  logic [XLEN_RA-1:0] id_rd,
    input  logic               id_regwrite,
    input  logic [1:0]         id_wb_sel,
    input  logic               ex_redirect,
    input  logic               dmem_busy,
    output logic               stall_f,
    output logic               stall_d,
    output logic               flush_d,
    output logic               flush_e,
    output logic               stall_all,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic               ex_valid_q, mem_valid_q, wb_valid_q;
    logic [XLEN_RA-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
    logic               ex_regwrite_q, mem_regwrite_q, wb_regwrite_q;
    logic [1:0]         ex_wb_sel_q, mem_wb_sel_q, wb_wb_sel_q;
    logic [XLEN_RA-1:0] ex_rs1_q, ex_rs2_q;
    logic [CNT_W-1:0]   stall_cnt_q, flush_cnt_q;

    logic               ex_valid_d;
    logic [XLEN_RA-1:0] ex_rd_d, ex_rs1_d, ex_rs2_d;
    logic               ex_regwrite_d;
    logic [1:0]         ex_wb_sel_d;
    logic [CNT_W-1:0]   stall_cnt_d, flush_cnt_d;

    logic ex_wr, mem_wr, wb_wr, load_use, bubble;

    always_comb begin
        ex_wr  = ex_valid_q  & ex_regwrite_q  & (ex_rd_q  != '0);
        mem_wr = mem_valid_q & mem_regwrite_q & (mem_rd_q != '0);
        wb_wr  = wb_valid_q  & wb_regwrite_q  & (wb_rd_q  != '0);
        load_use = ex_wr & (ex_wb_sel_q == WB_LOAD) &
                   ((id_use_rs1 & (id_rs1 == ex_rd_q)) |
                    (id_use_rs2 & (id_rs2 == ex_rd_q)));
        bubble = ex_redirect | load_use;
    end

    // Control outputs: busy beats redirect beats load-use. Everything is
    // gated by rst so the core sees a quiet controller while reset is held.
    always_comb begin
        stall_all = ~rst & dmem_busy;
        flush_d   = ~rst & ~dmem_busy & ex_redirect;
        flush_e   = ~rst & ~dmem_busy & bubble;
        stall_f   = ~rst & (dmem_busy | (~ex_redirect & load_use));
        stall_d   = stall_f;
    end

    // A load sitting in MEM has no data yet, so it never forwards from MEM.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (ex_valid_q) begin
            if (mem_wr && (mem_wb_sel_q != WB_LOAD) && (mem_rd_q == ex_rs1_q)) begin
                fwd_a = 2'b01;
            end else if (wb_wr && (wb_rd_q == ex_rs1_q)) begin
                fwd_a = 2'b10;
            end
            if (mem_wr && (mem_wb_sel_q != WB_LOAD) && (mem_rd_q == ex_rs2_q)) begin
                fwd_b = 2'b01;
            end else if (wb_wr && (wb_rd_q == ex_rs2_q)) begin
                fwd_b = 2'b10;
            end
        end
    end

    always_comb begin
        ex_valid_d    = 1'b0;
        ex_rd_d       = '0;
        ex_regwrite_d = 1'b0;
        ex_wb_sel_d   = 2'b00;
        ex_rs1_d      = '0;
        ex_rs2_d      = '0;
        if (!bubble) begin
            ex_valid_d    = 1'b1;
            ex_rd_d       = id_rd;
            ex_regwrite_d = id_regwrite;
            ex_wb_sel_d   = id_wb_sel;
            ex_rs1_d      = id_rs1;
            ex_rs2_d      = id_rs2;
        end
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (ex_redirect) begin
            if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else if (load_use) begin
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q     <= 1'b0;
            ex_rd_q        <= '0;
            ex_regwrite_q  <= 1'b0;
            ex_wb_sel_q    <= 2'b00;
            ex_rs1_q       <= '0;
            ex_rs2_q       <= '0;
            mem_valid_q    <= 1'b0;
            mem_rd_q       <= '0;
            mem_regwrite_q <= 1'b0;
            mem_wb_sel_q   <= 2'b00;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= '0;
            wb_regwrite_q  <= 1'b0;
            wb_wb_sel_q    <= 2'b00;
            stall_cnt_q    <= '0;
            flush_cnt_q    <= '0;
        end else if (!dmem_busy) begin
            ex_valid_q     <= ex_valid_d;
            ex_rd_q        <= ex_rd_d;
            ex_regwrite_q  <= ex_regwrite_d;
            ex_wb_sel_q    <= ex_wb_sel_d;
            ex_rs1_q       <= ex_rs1_d;
            ex_rs2_q       <= ex_rs2_d;
            mem_valid_q    <= ex_valid_q;
            mem_rd_q       <= ex_rd_q;
            mem_regwrite_q <= ex_regwrite_q;
            mem_wb_sel_q   <= ex_wb_sel_q;
            wb_valid_q     <= mem_valid_q;
            wb_rd_q        <= mem_rd_q;
            wb_regwrite_q  <= mem_regwrite_q;
            wb_wb_sel_q    <= mem_wb_sel_q;
            stall_cnt_q    <= stall_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic          id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_regwrite = 1'b0;
    logic [1:0]    id_wb_sel = 2'b00;
    logic          ex_redirect = 1'b0, dmem_busy = 1'b0;
    logic          stall_f, stall_d, flush_d, flush_e, stall_all;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt, flush_cnt;

    hazard_controller #(.CNT_W(CW), .XLEN_RA(5)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_wb_sel(id_wb_sel),
        .ex_redirect(ex_redirect), .dmem_busy(dmem_busy),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .flush_e(flush_e), .stall_all(stall_all),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: an in-flight instruction list indexed by age
    // (0 = EX, 1 = MEM, 2 = WB) and plain integer counters.
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       rw;
        bit [1:0] ws;
        bit [4:0] rs1;
        bit [4:0] rs2;
    } instr_t;

    instr_t pipe[3];
    int     m_stalls, m_flushes;
    int     n_vec, n_bad;

    function automatic bit writes(instr_t e);
        return e.v && e.rw && (e.rd != 0);
    endfunction

    function automatic bit reads_load(instr_t ld);
        if (!(writes(ld) && ld.ws == 2'd1)) return 1'b0;
        return (id_use_rs1 && id_rs1 == ld.rd) || (id_use_rs2 && id_rs2 == ld.rd);
    endfunction

    function automatic int src_of(bit [4:0] r);
        if (!pipe[0].v) return 0;
        if (writes(pipe[1]) && pipe[1].ws != 2'd1 && pipe[1].rd == r) return 1;
        if (writes(pipe[2]) && pipe[2].rd == r) return 2;
        return 0;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
        m_stalls  = 0;
        m_flushes = 0;
    endtask

    task automatic check_outputs();
        int ctl;
        bit lu;
        lu = reads_load(pipe[0]);
        // ctl packs {stall_f, stall_d, flush_d, flush_e, stall_all}
        if (rst)              ctl = 0;
        else if (dmem_busy)   ctl = 5'b11001;
        else if (ex_redirect) ctl = 5'b00110;
        else if (lu)          ctl = 5'b11010;
        else                  ctl = 0;
        chk("ctl", int'({stall_f, stall_d, flush_d, flush_e, stall_all}), ctl);
        chk("fwd_a", int'(fwd_a), src_of(pipe[0].rs1));
        chk("fwd_b", int'(fwd_b), src_of(pipe[0].rs2));
        chk("stall_cnt", int'(stall_cnt), m_stalls);
        chk("flush_cnt", int'(flush_cnt), m_flushes);
    endtask

    task automatic model_clock();
        instr_t nxt;
        bit lu;
        if (rst) begin
            model_reset();
            return;
        end
        if (dmem_busy) return;
        lu = reads_load(pipe[0]);
        nxt = '{v: 1'b1, rd: id_rd, rw: id_regwrite, ws: id_wb_sel,
                rs1: id_rs1, rs2: id_rs2};
        if (ex_redirect || lu) nxt = '{default: 0};
        if (ex_redirect)      m_flushes = (m_flushes == 15) ? 15 : m_flushes + 1;
        else if (lu)          m_stalls  = (m_stalls  == 15) ? 15 : m_stalls  + 1;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = nxt;
    endtask

    // One cycle: inputs already driven just after the previous edge.
    task automatic cyc();
        #1 check_outputs();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic ins(input int rs1, input int rs2, input bit u1, input bit u2,
                       input int rd, input bit rw, input int ws);
        id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
        id_use_rs1 = u1;  id_use_rs2 = u2;
        id_rd = 5'(rd);   id_regwrite = rw; id_wb_sel = 2'(ws);
        ex_redirect = 1'b0; dmem_busy = 1'b0;
    endtask

    task automatic nop();
        ins(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        model_reset();
        dmem_busy = 1'b1; ex_redirect = 1'b1;
        #2 check_outputs();
        repeat (2) @(posedge clk);
        #3 check_outputs();
        @(negedge clk) rst = 1'b0;
        dmem_busy = 1'b0; ex_redirect = 1'b0;
        @(posedge clk); #1;

        // lw x5 ; add x6,x5,x1 : one stall, then WB forward on rs1
        ins(1, 0, 1, 0, 5, 1, 1); cyc();
        ins(5, 1, 1, 1, 6, 1, 0); cyc();
        chk("lu_stall_cnt", int'(stall_cnt), 1);
        cyc();
        nop(); cyc();
        nop(); repeat (3) cyc();

        // add x3 ; sub x4,x3,x3 back-to-back, then with a NOP between
        ins(1, 2, 1, 1, 3, 1, 0); cyc();
        ins(3, 3, 1, 1, 4, 1, 0); cyc();
        nop(); cyc();
        ins(1, 2, 1, 1, 3, 1, 0); cyc();
        nop(); cyc();
        ins(3, 3, 1, 1, 4, 1, 0); cyc();
        nop(); cyc();

        // x0 destination never forwards
        ins(0, 0, 1, 0, 0, 1, 0); cyc();
        ins(0, 0, 1, 1, 2, 1, 0); cyc();
        nop(); repeat (3) cyc();

        // redirect while ID depends on a load in EX
        ins(1, 0, 1, 0, 7, 1, 1); cyc();
        ins(7, 0, 1, 0, 8, 1, 0); ex_redirect = 1'b1; cyc();
        chk("redir_flush_cnt", int'(flush_cnt), 1);
        nop(); repeat (3) cyc();

        // dmem_busy for three cycles over a pending load-use
        ins(1, 0, 1, 0, 9, 1, 1); cyc();
        ins(9, 9, 1, 1, 10, 1, 0); dmem_busy = 1'b1;
        repeat (3) cyc();
        dmem_busy = 1'b0; cyc();
        cyc();
        chk("busy_stall_cnt", int'(stall_cnt), 2);
        nop(); repeat (3) cyc();

        // 20 redirects saturate the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            ins(i % 8, 0, 1, 0, i % 8, 1, 0); ex_redirect = 1'b1; cyc();
        end
        chk("flush_sat", int'(flush_cnt), 15);
        nop(); cyc();

        // async reset in the middle of a load-use stall
        ins(1, 0, 1, 0, 5, 1, 1); cyc();
        ins(5, 0, 1, 0, 6, 1, 0);
        #2 check_outputs();
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        chk("rst_ctl", int'({stall_f, stall_d, flush_e}), 0);
        @(posedge clk); #1 check_outputs();
        @(negedge clk) rst = 1'b0;
        @(posedge clk); model_clock(); #1;

        // random traffic over a small register window
        for (int i = 0; i < 600; i++) begin
            id_rs1      = 5'($urandom_range(0, 7));
            id_rs2      = 5'($urandom_range(0, 7));
            id_use_rs1  = 1'($urandom);
            id_use_rs2  = 1'($urandom);
            id_rd       = 5'($urandom_range(0, 7));
            id_regwrite = 1'($urandom);
            id_wb_sel   = 2'($urandom_range(0, 2));
            ex_redirect = ($urandom_range(0, 99) < 12);
            dmem_busy   = ($urandom_range(0, 99) < 15);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Pipeline hazard scheduler for the 5-stage RV32I core. It tracks the destination and write-back info of instructions in EX, MEM and WB in its own shadow pipeline, driven by the decoded control from the instruction decoder in ID. From that state it generates forwarding selects, load-use stalls, branch/jump flushes and global data-memory freezes. It also keeps saturating stall and flush event counters for performance debug.

Parameters:
CNT_W, 32, width of the stall and flush event counters
XLEN_RA, 5, register-address width

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
id_rs1  input  XLEN_RA  rs1 address of the instruction in ID
id_rs2  input  XLEN_RA  rs2 address of the instruction in ID
id_use_rs1  input  1  ID instruction reads rs1 (R, I, load, store, branch, JALR)
id_use_rs2  input  1  ID instruction reads rs2 (R, store, branch)
id_rd  input  XLEN_RA  destination of the ID instruction
id_regwrite  input  1  ID instruction writes the register file
id_wb_sel  input  2  ID write-back select: 00 ALU, 01 load, 10 PC+4
ex_redirect  input  1  taken branch, JAL or JALR resolved in EX this cycle
dmem_busy  input  1  data memory not ready; the whole pipe must freeze
stall_f  output  1  hold PC
stall_d  output  1  hold IF/ID register
flush_d  output  1  clear IF/ID register to NOP
flush_e  output  1  clear ID/EX register to NOP
stall_all  output  1  freeze ID/EX, EX/MEM and MEM/WB registers
fwd_a  output  2  EX operand A source: 00 regfile, 01 EX/MEM ALU result, 10 WB data
fwd_b  output  2  EX operand B source, same encoding as fwd_a
stall_cnt  output  CNT_W  load-use stall cycles, saturating
flush_cnt  output  CNT_W  redirect events, saturating

Behaviour:
- Shadow pipe: three entries (EX, MEM, WB). Each holds {valid, rd, regwrite, wb_sel}; the EX entry also holds rs1 and rs2.
- Reset (async on rst=1): all entries cleared (valid=0, regwrite=0, rd=0, wb_sel=00); both counters set to 0. While rst is held: all outputs 0, fwd_a/fwd_b = 00. Reset asserted mid-stall or mid-flush aborts the event immediately.
- Effective regwrite: "wr(X)" = valid & regwrite & (rd != 0). x0 never causes a hazard or a forward.
- Load-use hazard, combinational: EX.wr & EX.wb_sel==01 & ((id_use_rs1 & id_rs1==EX.rd) | (id_use_rs2 & id_rs2==EX.rd)).
- Priority each cycle: dmem_busy > ex_redirect > load-use > normal.
  - dmem_busy=1: stall_f=stall_d=stall_all=1; flush_d=flush_e=0. The shadow pipe holds, and counters hold. A redirect or load-use pending in the same cycle is re-evaluated once dmem_busy drops.
  - ex_redirect=1: flush_d=flush_e=1, stall_f=stall_d=0. On the clock edge, a bubble (valid=0) enters EX, and EX shifts to MEM and MEM to WB. flush_cnt increments by 1. A load-use in the same cycle is ignored because the ID instruction is being flushed.
  - load-use: stall_f=stall_d=1, flush_e=1. A bubble enters EX, EX advances to MEM. stall_cnt increments by 1. Exactly one stall cycle per load-use: after that, the load sits in MEM and the hazard clears.
  - normal: all controls 0. EX takes {1, id_rd, id_regwrite, id_wb_sel, id_rs1, id_rs2}; MEM and WB shift.
- Forwarding: combinational from the shadow pipe only, independent of the current ID inputs.
  - fwd_a = 01 if MEM.wr & MEM.wb_sel!=01 & MEM.rd==EX.rs1.
  - else fwd_a = 10 if WB.wr & WB.rd==EX.rs1.
  - else fwd_a = 00.
  - fwd_b is identical using EX.rs2.
  - MEM takes priority over WB (youngest producer wins).
  - A load in MEM never forwards from MEM; the load-use stall guarantees it is in WB before use.
  - fwd_a/fwd_b are forced to 00 when EX.valid=0.
- Counters: increment at most +1 per cycle and saturate at all-ones (no wrap).
- Latency: control outputs are combinational in the same cycle as the inputs; shadow-pipe effects are visible the next cycle.

Test Plan:
- Load-use: lw x5 then add x6,x5,x1 → 1 cycle with stall_f=stall_d=flush_e=1, stall_cnt 0→1; next cycle fwd_a=10.
- Back-to-back ALU: add x3,..; sub x4,x3,x3 → fwd_a=fwd_b=01, no stall. Same pair with one NOP between → fwd_a=fwd_b=10.
- x0 destination: addi x0,x0,1; add x2,x0,x0 → fwd_a=fwd_b=00, no stall.
- Redirect plus load-use in the same cycle: ex_redirect=1 while the ID instruction depends on a load in EX → flush_d=flush_e=1, stall_f=0; flush_cnt +1, stall_cnt unchanged.
- dmem_busy held 3 cycles during a load-use → stall_all=1 for 3 cycles, counters frozen; then the single load-use stall occurs and stall_cnt increments by exactly 1.
- Saturation and reset: with CNT_W=4, 20 redirects → flush_cnt=15. Assert rst asynchronously mid-stall → all outputs 0 immediately, counters 0.
